// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS control path: states, opcodes,
// funct codes, ALU operations and datapath select codes.
package mc_pkg;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_ADDIEX = 4'd11,
        S_ADDIWB = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_4      = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_control_if.sv
// Control <-> datapath signal bundle. master = the control FSM, slave = datapath.
interface multicycle_control_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       PCWrite;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegDst;
    logic       MemToReg;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [3:0] ALUOperation;
    logic [1:0] PCSource;
    logic       instr_done;
    logic       illegal;
    logic [3:0] state;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemToReg,
               RegWrite, ALUSrcA, ALUSrcB, ALUOperation, PCSource,
               instr_done, illegal, state
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemToReg,
               RegWrite, ALUSrcA, ALUSrcB, ALUOperation, PCSource,
               instr_done, illegal, state
    );
endinterface

// File: rtl/mc_alu_decoder.sv
// R-type funct -> ALU operation. Unknown funct codes fall back to ADD.
module mc_alu_decoder
    import mc_pkg::*;
(
    input  logic [5:0] funct,
    output logic [3:0] alu_op
);
    always_comb begin
        alu_op = ALU_ADD;
        case (funct)
            FN_SUB:  alu_op = ALU_SUB;
            FN_AND:  alu_op = ALU_AND;
            FN_OR:   alu_op = ALU_OR;
            FN_SLT:  alu_op = ALU_SLT;
            default: alu_op = ALU_ADD;
        endcase
    end
endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for a shared-memory multicycle MIPS datapath.
// Define MC_PERF_CNT_EN to add cycle_count / instr_count performance counters.
module multicycle_control
    import mc_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    multicycle_control_if.master   bus
`ifdef MC_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]       cycle_count,
    output logic [CNT_W-1:0]       instr_count
`endif
);
    state_t     st, nxt;
    logic [3:0] exec_op;

    mc_alu_decoder u_aludec (.funct(bus.funct), .alu_op(exec_op));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) st <= S_IDLE;
        else        st <= nxt;
    end

    assign bus.state = st;

    // Outputs decode only from the state register and live inputs, so an
    // asynchronous reset drops every strobe in the same instant.
    always_comb begin
        nxt              = st;
        bus.PCWrite      = 1'b0;
        bus.IorD         = 1'b0;
        bus.MemRead      = 1'b0;
        bus.MemWrite     = 1'b0;
        bus.IRWrite      = 1'b0;
        bus.RegDst       = 1'b0;
        bus.MemToReg     = 1'b0;
        bus.RegWrite     = 1'b0;
        bus.ALUSrcA      = 1'b0;
        bus.ALUSrcB      = SRCB_B;
        bus.ALUOperation = ALU_AND;
        bus.PCSource     = PC_ALU;
        bus.instr_done   = 1'b0;
        bus.illegal      = 1'b0;
        case (st)
            S_IDLE: nxt = S_FETCH;
            S_FETCH: begin
                bus.MemRead      = 1'b1;
                bus.ALUSrcB      = SRCB_4;
                bus.ALUOperation = ALU_ADD;
                if (bus.mem_ready) begin
                    bus.IRWrite = 1'b1;
                    bus.PCWrite = 1'b1;
                    nxt         = S_DECODE;
                end
            end
            S_DECODE: begin
                // Speculative branch target lands in ALUOut for BRANCH.
                bus.ALUSrcB      = SRCB_IMM_SH;
                bus.ALUOperation = ALU_ADD;
                case (bus.opcode)
                    OP_LW, OP_SW: nxt = S_MEMADR;
                    OP_RTYPE:     nxt = S_EXEC;
                    OP_BEQ:       nxt = S_BRANCH;
                    OP_J:         nxt = S_JUMP;
                    OP_ADDI:      nxt = S_ADDIEX;
                    default: begin
                        bus.illegal = 1'b1;
                        nxt         = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                bus.ALUSrcA      = 1'b1;
                bus.ALUSrcB      = SRCB_IMM;
                bus.ALUOperation = ALU_ADD;
                nxt              = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                bus.MemRead = 1'b1;
                bus.IorD    = 1'b1;
                if (bus.mem_ready) nxt = S_MEMWB;
            end
            S_MEMWB: begin
                bus.RegWrite   = 1'b1;
                bus.MemToReg   = 1'b1;
                bus.instr_done = 1'b1;
                nxt            = S_FETCH;
            end
            S_MEMWR: begin
                bus.MemWrite = 1'b1;
                bus.IorD     = 1'b1;
                if (bus.mem_ready) begin
                    bus.instr_done = 1'b1;
                    nxt            = S_FETCH;
                end
            end
            S_EXEC: begin
                bus.ALUSrcA      = 1'b1;
                bus.ALUOperation = exec_op;
                nxt              = S_ALUWB;
            end
            S_ALUWB: begin
                bus.RegWrite   = 1'b1;
                bus.RegDst     = 1'b1;
                bus.instr_done = 1'b1;
                nxt            = S_FETCH;
            end
            S_BRANCH: begin
                bus.ALUSrcA      = 1'b1;
                bus.ALUOperation = ALU_SUB;
                bus.PCSource     = PC_ALUOUT;
                bus.PCWrite      = bus.zero;
                bus.instr_done   = 1'b1;
                nxt              = S_FETCH;
            end
            S_JUMP: begin
                bus.PCSource   = PC_JUMP;
                bus.PCWrite    = 1'b1;
                bus.instr_done = 1'b1;
                nxt            = S_FETCH;
            end
            S_ADDIEX: begin
                bus.ALUSrcA      = 1'b1;
                bus.ALUSrcB      = SRCB_IMM;
                bus.ALUOperation = ALU_ADD;
                nxt              = S_ADDIWB;
            end
            S_ADDIWB: begin
                bus.RegWrite   = 1'b1;
                bus.instr_done = 1'b1;
                nxt            = S_FETCH;
            end
            default: nxt = S_IDLE;
        endcase
    end

`ifdef MC_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_count <= '0;
            instr_count <= '0;
        end else begin
            if (st != S_IDLE)   cycle_count <= cycle_count + 1'b1;
            if (bus.instr_done) instr_count <= instr_count + 1'b1;
        end
    end
`else
    logic unused_cnt_w;
    assign unused_cnt_w = ^CNT_W;
`endif

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore-style FSM that sequences a shared-memory, multicycle MIPS datapath: one memory port, one ALU, registered IR/A/B/ALUOut.
- Replaces the combinational single-cycle control path.
- Emits per-cycle datapath selects and enables, and waits on a memory-ready handshake.
- Supports R-type (add, sub, and, or, slt), lw, sw, beq, j, addi.

Parameters:
- CNT_W, 32, width of the performance counters (used only when MC_PERF_CNT_EN is defined).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- opcode  in  6  IR[31:26]; valid from DECODE onward
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- PCWrite  out  1  PC load enable, already qualified (includes branch taken)
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemRead  out  1  memory read strobe
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  instruction register load
- RegDst  out  1  write register select: 0 = rt, 1 = rd
- MemToReg  out  1  write data select: 0 = ALUOut, 1 = MDR
- RegWrite  out  1  register file write
- ALUSrcA  out  1  ALU A select: 0 = PC, 1 = register A
- ALUSrcB  out  2  ALU B select: 00 = B, 01 = const 4, 10 = sign-extended imm, 11 = sign-extended imm << 2
- ALUOperation  out  4  ALU op: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT
- PCSource  out  2  next-PC select: 00 = ALU, 01 = ALUOut, 10 = jump target
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction
- illegal  out  1  one-cycle pulse in DECODE for an unsupported opcode
- state  out  4  current state encoding (debug)

Behaviour:
- States and encodings: IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, ALUWB=8, BRANCH=9, JUMP=10, ADDIEX=11, ADDIWB=12.
- Reset: asynchronous, forces state=IDLE. In IDLE all outputs are 0. IDLE always goes to FETCH on the next clk edge.
- Outputs are a pure decode of the state register plus zero/mem_ready/opcode/funct. They are never registered separately.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOperation=ADD, PCSource=00.
  - mem_ready=0: stay in FETCH; IRWrite=0, PCWrite=0.
  - mem_ready=1: IRWrite=1, PCWrite=1, next state DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOperation=ADD (branch target into ALUOut). Next state by opcode:
  - 0x23 or 0x2B: MEMADR
  - 0x00: EXEC
  - 0x04: BRANCH
  - 0x02: JUMP
  - 0x08: ADDIEX
  - any other opcode: illegal=1, next FETCH (instruction dropped; PC has already advanced).
- MEMADR: ALUSrcA=1, ALUSrcB=10, ADD. Next MEMRD for lw, MEMWR for sw.
- MEMRD: MemRead=1, IorD=1. Hold while mem_ready=0; next MEMWB when mem_ready=1.
- MEMWB: RegWrite=1, MemToReg=1, RegDst=0, instr_done=1. Next FETCH.
- MEMWR: MemWrite=1, IorD=1. Hold while mem_ready=0. When mem_ready=1: instr_done=1, next FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOperation from funct:
  - 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT
  - any other funct decodes to ADD (no trap).
  - Next ALUWB.
- ALUWB: RegWrite=1, RegDst=1, MemToReg=0, instr_done=1. Next FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, SUB, PCSource=01, PCWrite=zero, instr_done=1. Next FETCH.
- JUMP: PCSource=10, PCWrite=1, instr_done=1. Next FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ADD. Next ADDIWB.
- ADDIWB: RegWrite=1, RegDst=0, MemToReg=0, instr_done=1. Next FETCH.
- Cycle counts with mem_ready held at 1: R-type 4, lw 5, sw 4, beq 3, j 3, addi 4. Each mem_ready=0 cycle in FETCH/MEMRD/MEMWR adds one cycle.
- MemRead and MemWrite are never both 1 in the same cycle. RegWrite and MemWrite are never both 1 in the same cycle.
- Reset asserted mid-instruction: state goes to IDLE immediately; any pending write strobe drops asynchronously. No partial writeback occurs after reset.

Optional Feature:
- Macro: MC_PERF_CNT_EN.
- When defined, add two output ports:
  - cycle_count [CNT_W]: increments every cycle the state is not IDLE.
  - instr_count [CNT_W]: increments on every instr_done.
- Both counters clear on reset and wrap modulo 2^CNT_W.
- When not defined, neither the ports nor the counter logic exist.

Decomposition:
- Package mc_pkg holds:
  - state encodings
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI
  - funct constants
  - ALUOperation codes
  - ALUSrcB and PCSource select codes
- Sub-module mc_alu_decoder: combinational funct -> ALUOperation, used in EXEC only.

Test Plan:
- Reset: hold reset=0 for 3 cycles -> state=0, all outputs 0. Release -> FETCH on the next edge, then MemRead=1.
- add with opcode=0x00, funct=0x20, mem_ready=1 -> states 1,2,7,8. ALUOperation=0010 in EXEC. RegWrite=1 and RegDst=1 in ALUWB. instr_done pulses once.
- lw with opcode=0x23 and mem_ready=0 for 2 cycles in MEMRD -> state holds at 4 for 3 cycles. MEMWB asserts RegWrite=1, MemToReg=1. Total 7 cycles.
- beq with opcode=0x04: zero=1 -> PCWrite=1, PCSource=01 in BRANCH. zero=0 -> PCWrite=0. Both return to FETCH.
- Illegal opcode 0x3F -> illegal pulses in DECODE, next state FETCH, RegWrite and MemWrite never asserted.
- sw with reset asserted during MEMWR (mem_ready=0) -> MemWrite drops to 0 asynchronously, state=0; with MC_PERF_CNT_EN defined, both counters read 0.
